// File: rtl/ufpu_sched_pipe.sv
// Two-stage valid/ready filter/pick unit: pass, mask, predicate filter, argmin, random and WRR pick.
// Optional macro UFPU_ARGMAX_EN enables opcode 110 (argmax); otherwise 110 is illegal.
module ufpu_sched_pipe #(
  parameter int BIT_VEC_SIZE     = 64,
  parameter int BIT_VEC_SIZE_LOG = $clog2(BIT_VEC_SIZE),
  parameter int VAL_W            = 16,
  parameter logic [BIT_VEC_SIZE_LOG-1:0] LFSR_SEED = BIT_VEC_SIZE_LOG'(1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [BIT_VEC_SIZE-1:0]       i_in,
  input  logic [BIT_VEC_SIZE*VAL_W-1:0] i_metrics,
  input  logic [2:0]                    i_opcode,
  input  logic [BIT_VEC_SIZE_LOG-1:0]   i_id,
  input  logic [VAL_W-1:0]              i_val,
  input  logic [2:0]                    i_pred_op,
  input  logic                          i_valid_in,
  output logic                          o_ready_in,
  output logic [BIT_VEC_SIZE-1:0]       o_out,
  output logic [BIT_VEC_SIZE_LOG-1:0]   o_out_id,
  output logic                          o_out_empty,
  output logic                          o_err,
  output logic                          o_valid_out,
  input  logic                          i_ready_out
);
  localparam int N = BIT_VEC_SIZE;
  localparam int L = BIT_VEC_SIZE_LOG;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      2:  return 32'h0003;
      3:  return 32'h0006;
      4:  return 32'h000C;
      5:  return 32'h0014;
      6:  return 32'h0030;
      7:  return 32'h0060;
      8:  return 32'h00B8;
      9:  return 32'h0110;
      10: return 32'h0240;
      11: return 32'h0500;
      12: return 32'h0829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h6000;
      16: return 32'hD008;
      default: return 32'h0003;
    endcase
  endfunction

  localparam logic [L-1:0] LFSR_TAPS = L'(lfsr_taps(L));

  function automatic logic pred_f(input logic [2:0] op, input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
    case (op)
      3'b000:  return a < b;
      3'b001:  return a > b;
      3'b010:  return a <= b;
      3'b011:  return a >= b;
      3'b100:  return a == b;
      3'b101:  return a != b;
      default: return 1'b0;
    endcase
  endfunction

  logic                 r_s1_valid;
  logic [N-1:0]         r_s1_in;
  logic [N*VAL_W-1:0]   r_s1_metrics;
  logic [2:0]           r_s1_opcode;
  logic [L-1:0]         r_s1_id;
  logic [VAL_W-1:0]     r_s1_val;
  logic [2:0]           r_s1_pred_op;
  logic [L-1:0]         r_lfsr;
  logic [L-1:0]         r_last_id;
  logic [VAL_W:0]       r_w;

  logic                 w_s2_load;
  logic [N-1:0]         w_res;
  logic [L-1:0]         w_res_id;
  logic                 w_res_err;
  logic                 w_is_pick;
  logic                 w_found;
  logic [L-1:0]         w_pick;
  logic [L-1:0]         w_idx;
  logic [VAL_W-1:0]     w_best;
  logic [VAL_W-1:0]     w_weight;
  logic                 w_wrr_upd;
  logic [L-1:0]         w_last_nxt;
  logic [VAL_W:0]       w_w_nxt;

  assign w_s2_load  = !o_valid_out || i_ready_out;
  assign o_ready_in = !r_s1_valid || w_s2_load;

  always_comb begin
    w_res      = '0;
    w_res_id   = '0;
    w_res_err  = 1'b0;
    w_is_pick  = 1'b0;
    w_found    = 1'b0;
    w_pick     = '0;
    w_idx      = '0;
    w_best     = '0;
    w_weight   = '0;
    w_wrr_upd  = 1'b0;
    w_last_nxt = r_last_id;
    w_w_nxt    = r_w;
    case (r_s1_opcode)
      3'b000: w_res = r_s1_in;
      3'b001: w_res[r_s1_id] = r_s1_in[r_s1_id];
      3'b010: begin
        if (r_s1_pred_op[2:1] == 2'b11) w_res_err = 1'b1;
        else
          for (int i = 0; i < N; i++)
            w_res[i] = r_s1_in[i] & pred_f(r_s1_pred_op, r_s1_metrics[i*VAL_W +: VAL_W], r_s1_val);
      end
      3'b011: begin
        w_is_pick = 1'b1;
        for (int i = 0; i < N; i++)
          if (r_s1_in[i] && (!w_found || r_s1_metrics[i*VAL_W +: VAL_W] < w_best)) begin
            w_found = 1'b1;
            w_best  = r_s1_metrics[i*VAL_W +: VAL_W];
            w_pick  = L'(i);
          end
      end
      3'b100: begin
        w_is_pick = 1'b1;
        for (int k = 0; k < N; k++) begin
          w_idx = r_lfsr + L'(k);
          if (!w_found && r_s1_in[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
          end
        end
      end
      3'b101: begin
        w_is_pick = 1'b1;
        w_weight  = r_s1_metrics[r_last_id*VAL_W +: VAL_W];
        if (w_weight == '0) w_weight = {{(VAL_W-1){1'b0}}, 1'b1};
        if (r_s1_in[r_last_id] && (r_w < {1'b0, w_weight})) begin
          w_found = 1'b1;
          w_pick  = r_last_id;
          w_w_nxt = (&r_w) ? r_w : r_w + {{VAL_W{1'b0}}, 1'b1};
        end else begin
          // k == N wraps back to last_id itself when it is the only candidate
          for (int k = 1; k <= N; k++) begin
            w_idx = r_last_id + L'(k);
            if (!w_found && r_s1_in[w_idx]) begin
              w_found = 1'b1;
              w_pick  = w_idx;
            end
          end
          w_last_nxt = w_pick;
          w_w_nxt    = {{VAL_W{1'b0}}, 1'b1};
        end
        w_wrr_upd = w_found;
      end
`ifdef UFPU_ARGMAX_EN
      3'b110: begin
        w_is_pick = 1'b1;
        for (int i = 0; i < N; i++)
          if (r_s1_in[i] && (!w_found || r_s1_metrics[i*VAL_W +: VAL_W] > w_best)) begin
            w_found = 1'b1;
            w_best  = r_s1_metrics[i*VAL_W +: VAL_W];
            w_pick  = L'(i);
          end
      end
`endif
      default: w_res_err = 1'b1;
    endcase
    if (w_is_pick && w_found) begin
      w_res         = '0;
      w_res[w_pick] = 1'b1;
      w_res_id      = w_pick;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_in      <= '0;
      r_s1_metrics <= '0;
      r_s1_opcode  <= '0;
      r_s1_id      <= '0;
      r_s1_val     <= '0;
      r_s1_pred_op <= '0;
      r_lfsr       <= LFSR_SEED;
      r_last_id    <= '0;
      r_w          <= '0;
      o_valid_out  <= 1'b0;
      o_out        <= '0;
      o_out_id     <= '0;
      o_out_empty  <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[L-2:0], ^(r_lfsr & LFSR_TAPS)};
      if (o_ready_in) begin
        r_s1_valid <= i_valid_in;
        if (i_valid_in) begin
          r_s1_in      <= i_in;
          r_s1_metrics <= i_metrics;
          r_s1_opcode  <= i_opcode;
          r_s1_id      <= i_id;
          r_s1_val     <= i_val;
          r_s1_pred_op <= i_pred_op;
        end
      end
      if (w_s2_load) begin
        o_valid_out <= r_s1_valid;
        if (r_s1_valid) begin
          o_out       <= w_res;
          o_out_id    <= w_res_id;
          o_out_empty <= (w_res == '0);
          o_err       <= w_res_err;
          if (w_wrr_upd) begin
            r_last_id <= w_last_nxt;
            r_w       <= w_w_nxt;
          end
        end
      end
    end
  end
endmodule
